// File: rtl/des_key_schedule_if.sv
// -----------------------------------------------------------------------------
// des_key_schedule_if
//
// Bundles the key-input and C||D-output handshakes of the DES key schedule.
//
// Modports
//   master : the key-schedule generator. It takes key_in/key_valid/cd_ready
//            and drives key_ready, cd_out, cd_valid, round, iter and last.
//   slave  : the key source plus the downstream PC-2 consumer. It drives the
//            key and the ready signal and observes the beat stream.
//
// Signals
//   key_in    [0:63] DES key; bit 0 is the MSB of the first key byte
//   key_valid        key_in is valid
//   key_ready        generator can take a key this cycle
//   cd_out    [0:55] C||D after the round's rotation (C = [0:27], D = [28:55])
//   cd_valid         cd_out/round/iter/last are valid
//   cd_ready         consumer accepts the current beat
//   round     [3:0]  0..15, meaning DES rounds 1..16
//   iter      [5:0]  pass number, 0..ITERATIONS-1
//   last             final beat for the current key
// -----------------------------------------------------------------------------
interface des_key_schedule_if;
    logic [0:63] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [0:55] cd_out;
    logic        cd_valid;
    logic        cd_ready;
    logic [3:0]  round;
    logic [5:0]  iter;
    logic        last;

    modport master (
        input  key_in,
        input  key_valid,
        input  cd_ready,
        output key_ready,
        output cd_out,
        output cd_valid,
        output round,
        output iter,
        output last
    );

    modport slave (
        output key_in,
        output key_valid,
        output cd_ready,
        input  key_ready,
        input  cd_out,
        input  cd_valid,
        input  round,
        input  iter,
        input  last
    );
endinterface

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//
// Sequential DES key-schedule generator for the descrypt core. A 64-bit key is
// permuted through PC-1 into C0||D0, then one rotated C||D value is streamed per
// accepted beat. Each key produces 16 rounds repeated ITERATIONS times. The
// downstream (combinational) PC-2 stage turns each beat into a round subkey.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; abandons any sequence in flight
//   bus  : des_key_schedule_if.master
//            key_in/key_valid/key_ready  key handshake (key_ready is the only
//                                        combinational output)
//            cd_out/round/iter/last      beat payload, registered
//            cd_valid/cd_ready           beat handshake
//
// Parameters
//   ITERATIONS : 16-round passes per key, 1..63
// -----------------------------------------------------------------------------
module des_key_schedule #(
    parameter int ITERATIONS = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    des_key_schedule_if.master    bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // FIPS 46-3 PC-1, 1-based key bit numbers. First 28 entries build C0,
    // the remaining 28 build D0.
    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam logic [5:0] ITER_LAST  = 6'(ITERATIONS - 1);
    localparam logic [3:0] ROUND_LAST = 4'd15;

    // -------------------------------------------------------------------------
    // Registers and their next values
    // -------------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [0:55] cd_reg, cd_next;
    logic [3:0]  round_reg, round_next;
    logic [5:0]  iter_reg, iter_next;
    logic        last_reg, last_next;
    logic        cd_valid_reg, cd_valid_next;

    // FSM-decoded strobes
    logic        key_ready_int;
    logic        load_key;     // key accepted this cycle
    logic        advance;      // non-final beat handed off, step to next round
    logic        finish;       // final beat handed off, drop cd_valid

    // -------------------------------------------------------------------------
    // Permutation and rotation networks (pure wiring)
    // -------------------------------------------------------------------------
    logic [0:55] pc1_cd;       // C0||D0
    logic [0:55] pc1_rot1;     // C0||D0 with each half rotated left by 1
    logic [0:55] cd_rot1;      // current C||D, halves rotated left by 1
    logic [0:55] cd_rot2;      // current C||D, halves rotated left by 2

    // Each output bit gi picks its source inside its own 28-bit half, so C and
    // D rotate independently. With bit 0 as MSB, a left rotation by n means
    // position p takes the old bit at (p + n) mod 28.
    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_bits
            localparam int HALF = (gi < 28) ? 0 : 28;
            localparam int POS  = gi - HALF;
            localparam int SRC1 = HALF + ((POS + 1) % 28);
            localparam int SRC2 = HALF + ((POS + 2) % 28);
            localparam int KSRC = PC1_TABLE[gi] - 1;

            assign pc1_cd[gi]   = bus.key_in[KSRC];
            assign pc1_rot1[gi] = pc1_cd[SRC1];
            assign cd_rot1[gi]  = cd_reg[SRC1];
            assign cd_rot2[gi]  = cd_reg[SRC2];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round / pass bookkeeping for the step to the next beat
    // -------------------------------------------------------------------------
    logic [3:0] round_inc;
    logic [5:0] iter_inc;
    logic       shift_one;

    assign round_inc = round_reg + 4'd1;     // 15 wraps naturally to 0
    assign iter_inc  = (round_reg == ROUND_LAST) ? (iter_reg + 6'd1) : iter_reg;

    // DES rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) rotate by one place,
    // all others by two. Index 0 is reached again at the start of each pass,
    // which is why the single-step path also exists for the running state.
    assign shift_one = (round_inc == 4'd0) || (round_inc == 4'd1) ||
                       (round_inc == 4'd8) || (round_inc == 4'd15);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.key_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cd_valid_reg && bus.cd_ready && last_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output decode
    // -------------------------------------------------------------------------
    // key_ready is gated by rst so that a source never sees a handshake that
    // the reset is about to discard.
    always_comb begin
        key_ready_int = 1'b0;
        load_key      = 1'b0;
        advance       = 1'b0;
        finish        = 1'b0;
        case (state_reg)
            IDLE: begin
                key_ready_int = !rst;
                load_key      = bus.key_valid && !rst;
            end
            RUN: begin
                advance = cd_valid_reg && bus.cd_ready && !last_reg;
                finish  = cd_valid_reg && bus.cd_ready && last_reg;
            end
            default: begin
                key_ready_int = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    // Without a strobe everything holds, which keeps the beat stable for the
    // whole duration of a consumer stall. A full pass rotates each half by 28
    // places in total, so passes chain without reloading C0||D0.
    always_comb begin
        cd_next       = cd_reg;
        round_next    = round_reg;
        iter_next     = iter_reg;
        last_next     = last_reg;
        cd_valid_next = cd_valid_reg;

        if (load_key) begin
            cd_next       = pc1_rot1;
            round_next    = 4'd0;
            iter_next     = 6'd0;
            last_next     = 1'b0;          // round 0 can never be the final beat
            cd_valid_next = 1'b1;
        end else if (advance) begin
            cd_next       = shift_one ? cd_rot1 : cd_rot2;
            round_next    = round_inc;
            iter_next     = iter_inc;
            last_next     = (round_inc == ROUND_LAST) && (iter_inc == ITER_LAST);
            cd_valid_next = 1'b1;
        end else if (finish) begin
            cd_valid_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cd_reg       <= '0;
            round_reg    <= 4'd0;
            iter_reg     <= 6'd0;
            last_reg     <= 1'b0;
            cd_valid_reg <= 1'b0;
        end else begin
            cd_reg       <= cd_next;
            round_reg    <= round_next;
            iter_reg     <= iter_next;
            last_reg     <= last_next;
            cd_valid_reg <= cd_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.key_ready = key_ready_int;
    assign bus.cd_out    = cd_reg;
    assign bus.cd_valid  = cd_valid_reg;
    assign bus.round     = round_reg;
    assign bus.iter      = iter_reg;
    assign bus.last      = last_reg;

endmodule
